mdu_hilo: RTL and testbench
===========================

// Module: mdu_hilo
// PURPOSE
//  Multiply/divide unit that executes the 3-bit mdu command decoded by the CPU control unit and owns the HI/LO registers.
//  Iterative 32-step shift-add multiplier and restoring divider; raises stall so the single-cycle datapath holds the instruction.
//  Sits beside the ALU; hi/lo feed the control unit's MFHI/MFLO writeback path.
// PARAMETERS
//  DATA_W  32  operand/HI/LO width; only 32 supported (iteration counter sized as clog2(DATA_W)+1)
// PORTS
//  clk     in   1   system clock; all state updates on rising edge
//  rst     in   1   reset, synchronous, active-high
//  mdu     in   3   command: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 treated as none
//  rdata1  in   32  rs operand (multiplicand/dividend; MTHI/MTLO source)
//  rdata2  in   32  rt operand (multiplier/divisor)
//  hi      out  32  HI register (product[63:32] / remainder)
//  lo      out  32  LO register (product[31:0] / quotient)
//  stall   out  1   combinational; high while an iterative command is pending/running
// BEHAVIOUR
//  Reset: state=IDLE, hi=0, lo=0, counter=0, operand/accumulator regs=0, stall=0. Reset mid-operation aborts; no HI/LO write.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//   IDLE: mdu in {1..4}: latch |rdata1|,|rdata2| (magnitudes for 1/3, raw for 2/4), latch cmd and sign bits, counter=0, -> RUN.
//         mdu=5: hi<=rdata1 at edge; mdu=6: lo<=rdata1; stay IDLE, stall=0. mdu in {0,7}: nothing.
//   RUN:  one multiply or divide step per cycle, counter++; on counter==31 step, write fixed-up result to hi/lo, -> DONE.
//   DONE: stall=0 so CPU commits the instruction; mdu ignored (same instruction still present); -> IDLE unconditionally.
//  stall = (state==IDLE && mdu in {1..4}) || state==RUN. Low in DONE and for MTHI/MTLO.
//  Latency: command seen in cycle 0; hi/lo valid from cycle 33; stall high exactly 33 cycles (0..32).
//  mdu changes while RUN: ignored; operands/cmd used are those latched in IDLE.
//  Multiply: 64-bit accumulator, shift-add on multiplier LSB, multiplicand shifted left. MULT: negate 64-bit product if sign(a)^sign(b).
//  Divide: restoring, 33-bit partial remainder; quotient bit = (rem>=divisor). DIV: quotient negated if sign(a)^sign(b), remainder takes sign(a).
//  Divide by zero (DIV and DIVU): natural restoring result, defined as lo=32'hFFFF_FFFF, hi=dividend magnitude before sign fixup;
//   DIV applies the normal sign fixups to both.
//  DIV 32'h8000_0000 / 32'hFFFF_FFFF: lo=32'h8000_0000, hi=0 (no trap).
//  hi/lo hold value whenever not written; MTHI/MTLO never touch the other register.
// STRUCTURE
//  Shared package (with control unit):
//   - mdu command localparams MDU_NONE/MULT/MULTU/DIV/DIVU/MTHI/MTLO
//   - FSM state encoding
//   - DATA_W
//  Sub-module mdu_seq_core: per-cycle step datapath (accumulator, shift, add/sub, quotient bit) with sign fixup.
//  mdu_hilo keeps the FSM, counter, operand latch and HI/LO registers.
// TESTING
//  MULT rdata1=32'hFFFF_FFFF rdata2=2 -> hi=FFFF_FFFF lo=FFFF_FFFE at cycle 33, stall high cycles 0..32 exactly.
//  MULTU rdata1=32'hFFFF_FFFF rdata2=2 -> hi=0000_0001 lo=FFFF_FFFE.
//  DIV rdata1=-7 rdata2=2 -> lo=FFFF_FFFD hi=FFFF_FFFF; DIVU 7/0 -> lo=FFFF_FFFF hi=7.
//  DIV 8000_0000/FFFF_FFFF -> lo=8000_0000 hi=0; MTHI 1234 then MTLO 5678 back-to-back -> hi=1234 lo=5678, stall never high.
//  Reset pulsed at cycle 10 of DIVU 100/3 with mdu held -> hi=lo=0, stall=0 while rst high, restarts from IDLE.
//  Back-to-back MULTU then DIVU (mdu changes only after DONE) -> both results correct, each stall window 33 cycles.

Source files
------------

// File: rtl/mdu_hilo_pkg.sv
// Shared definitions for the multiply/divide unit and the CPU control unit:
// command codes, FSM encoding, datapath width and small arithmetic helpers.
package mdu_hilo_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = $clog2(DATA_W) + 1;

    localparam logic [2:0] MDU_NONE  = 3'd0;
    localparam logic [2:0] MDU_MULT  = 3'd1;
    localparam logic [2:0] MDU_MULTU = 3'd2;
    localparam logic [2:0] MDU_DIV   = 3'd3;
    localparam logic [2:0] MDU_DIVU  = 3'd4;
    localparam logic [2:0] MDU_MTHI  = 3'd5;
    localparam logic [2:0] MDU_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    function automatic logic is_iter(input logic [2:0] cmd);
        return (cmd == MDU_MULT) || (cmd == MDU_MULTU) ||
               (cmd == MDU_DIV)  || (cmd == MDU_DIVU);
    endfunction

    function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] v);
        return ~v + {{(DATA_W-1){1'b0}}, 1'b1};
    endfunction

    // Signed commands work on magnitudes; the sign is restored after the last step.
    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                    input logic sgn);
        return (sgn && v[DATA_W-1]) ? neg_w(v) : v;
    endfunction

endpackage

// File: rtl/mdu_hilo_if.sv
// CPU-side bus of the multiply/divide unit: command, operands, HI/LO and stall.
interface mdu_hilo_if;

    logic [2:0]                      mdu;
    logic [mdu_hilo_pkg::DATA_W-1:0] rdata1;
    logic [mdu_hilo_pkg::DATA_W-1:0] rdata2;
    logic [mdu_hilo_pkg::DATA_W-1:0] hi;
    logic [mdu_hilo_pkg::DATA_W-1:0] lo;
    logic                            stall;

    modport master (output mdu, rdata1, rdata2, input hi, lo, stall);
    modport slave  (input mdu, rdata1, rdata2, output hi, lo, stall);

endinterface

// File: rtl/mdu_hilo_seq_core.sv
// One shift-add multiply or restoring divide step per enabled cycle, plus the
// sign fixup applied to the values the current step produces.
module mdu_seq_core
    import mdu_hilo_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    input  logic              first,
    input  logic              is_div,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic              neg_q,
    input  logic              neg_r,
    output logic [DATA_W-1:0] res_hi,
    output logic [DATA_W-1:0] res_lo
);

    localparam int W2 = 2 * DATA_W;

    logic [W2-1:0]     acc_r, mcand_r;
    logic [DATA_W-1:0] shr_r, rem_r;

    logic [W2-1:0]     cur_acc_s, cur_mcand_s, acc_nx_s, mcand_nx_s, prod_s;
    logic [DATA_W-1:0] cur_shr_s, cur_rem_s, shr_nx_s, rem_nx_s, quo_s, rem_f_s;
    logic [DATA_W:0]   trial_s, dvs_s;
    logic              qbit_s;

    // Step datapath; on the first step the working registers are seeded from the operands.
    always_comb begin
        cur_acc_s   = first ? {W2{1'b0}} : acc_r;
        cur_mcand_s = first ? {{DATA_W{1'b0}}, op_a} : mcand_r;
        cur_shr_s   = first ? (is_div ? op_a : op_b) : shr_r;
        cur_rem_s   = first ? {DATA_W{1'b0}} : rem_r;

        acc_nx_s    = cur_shr_s[0] ? (cur_acc_s + cur_mcand_s) : cur_acc_s;
        mcand_nx_s  = {cur_mcand_s[W2-2:0], 1'b0};

        // Remainder stays below the divisor, so the 33-bit trial always fits back in 32 bits.
        trial_s  = {cur_rem_s, cur_shr_s[DATA_W-1]};
        dvs_s    = {1'b0, op_b};
        qbit_s   = (trial_s >= dvs_s);
        rem_nx_s = qbit_s ? DATA_W'(trial_s - dvs_s) : trial_s[DATA_W-1:0];

        if (is_div) begin
            shr_nx_s = {cur_shr_s[DATA_W-2:0], qbit_s};
        end else begin
            shr_nx_s = {1'b0, cur_shr_s[DATA_W-1:1]};
        end

        prod_s  = neg_q ? (~acc_nx_s + {{(W2-1){1'b0}}, 1'b1}) : acc_nx_s;
        quo_s   = neg_q ? neg_w(shr_nx_s) : shr_nx_s;
        rem_f_s = neg_r ? neg_w(rem_nx_s) : rem_nx_s;

        if (is_div) begin
            res_hi = rem_f_s;
            res_lo = quo_s;
        end else begin
            res_hi = prod_s[W2-1:DATA_W];
            res_lo = prod_s[DATA_W-1:0];
        end
    end

    // Working registers advance only while a step is enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r   <= {W2{1'b0}};
            mcand_r <= {W2{1'b0}};
            shr_r   <= {DATA_W{1'b0}};
            rem_r   <= {DATA_W{1'b0}};
        end else if (step) begin
            acc_r   <= acc_nx_s;
            mcand_r <= mcand_nx_s;
            shr_r   <= shr_nx_s;
            rem_r   <= rem_nx_s;
        end else begin
            acc_r   <= acc_r;
            mcand_r <= mcand_r;
            shr_r   <= shr_r;
            rem_r   <= rem_r;
        end
    end

endmodule

// File: rtl/mdu_hilo.sv
// Multiply/divide unit owning HI/LO: command FSM, iteration counter, operand
// latch and the HI/LO registers around the iterative step core.
module mdu_hilo
    import mdu_hilo_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    mdu_hilo_if.slave  bus
);

    mdu_state_e        state_r;
    logic [CNT_W-1:0]  count_r;
    logic [2:0]        cmd_r;
    logic [DATA_W-1:0] op_a_r, op_b_r, hi_r, lo_r;
    logic              neg_q_r, neg_r_r;

    logic              start_s, run_s, first_s, last_s, is_div_s, sgn_op_s;
    logic [DATA_W-1:0] res_hi_s, res_lo_s;

    // Command decode and step control.
    always_comb begin
        start_s  = (state_r == ST_IDLE) && is_iter(bus.mdu);
        sgn_op_s = (bus.mdu == MDU_MULT) || (bus.mdu == MDU_DIV);
        run_s    = (state_r == ST_RUN);
        first_s  = (count_r == {CNT_W{1'b0}});
        last_s   = run_s && (count_r == CNT_W'(DATA_W - 1));
        is_div_s = (cmd_r == MDU_DIV) || (cmd_r == MDU_DIVU);
    end

    // Stall covers the decode cycle so the CPU holds the instruction until DONE.
    assign bus.stall = ~rst & (start_s | run_s);
    assign bus.hi    = hi_r;
    assign bus.lo    = lo_r;

    mdu_seq_core u_core (
        .clk    (clk),
        .rst    (rst),
        .step   (run_s),
        .first  (first_s),
        .is_div (is_div_s),
        .op_a   (op_a_r),
        .op_b   (op_b_r),
        .neg_q  (neg_q_r),
        .neg_r  (neg_r_r),
        .res_hi (res_hi_s),
        .res_lo (res_lo_s)
    );

    // Command FSM with operand latch and HI/LO writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            count_r <= {CNT_W{1'b0}};
            cmd_r   <= MDU_NONE;
            op_a_r  <= {DATA_W{1'b0}};
            op_b_r  <= {DATA_W{1'b0}};
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            hi_r    <= {DATA_W{1'b0}};
            lo_r    <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        cmd_r   <= bus.mdu;
                        op_a_r  <= magnitude(bus.rdata1, sgn_op_s);
                        op_b_r  <= magnitude(bus.rdata2, sgn_op_s);
                        neg_q_r <= sgn_op_s & (bus.rdata1[DATA_W-1] ^ bus.rdata2[DATA_W-1]);
                        neg_r_r <= sgn_op_s & bus.rdata1[DATA_W-1];
                        count_r <= {CNT_W{1'b0}};
                        state_r <= ST_RUN;
                    end else if (bus.mdu == MDU_MTHI) begin
                        hi_r <= bus.rdata1;
                    end else if (bus.mdu == MDU_MTLO) begin
                        lo_r <= bus.rdata1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (last_s) begin
                        hi_r    <= res_hi_s;
                        lo_r    <= res_lo_s;
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed vector table, MTHI/MTLO and reset
// corner sequences, then random commands against an arithmetic reference model.
module tb_mdu_hilo;
    import mdu_hilo_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mdu_hilo_if bus ();

    mdu_hilo dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [2:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t        tbl [10];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference results straight from the arithmetic definitions.
    function automatic void ref_op(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] h, output logic [31:0] l);
        longint          sa, sb, p, r;
        longint unsigned up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        h  = 32'd0;
        l  = 32'd0;
        case (cmd)
            MDU_MULT:  begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
            MDU_MULTU: begin up = {32'd0, a} * {32'd0, b}; h = up[63:32]; l = up[31:0]; end
            MDU_DIVU: begin
                if (b == 32'd0) begin h = a; l = 32'hFFFF_FFFF; end
                else begin h = a % b; l = a / b; end
            end
            MDU_DIV: begin
                // Divide by zero: quotient all ones (negated if dividend negative), remainder = dividend
                if (b == 32'd0) begin h = a; l = a[31] ? 32'd1 : 32'hFFFF_FFFF; end
                else begin p = sa / sb; r = sa % sb; h = r[31:0]; l = p[31:0]; end
            end
            default: begin h = 32'd0; l = 32'd0; end
        endcase
    endfunction

    // Starts at posedge+1, runs one iterative command, ends at posedge+1 with mdu idle.
    task automatic do_iter(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eh, input logic [31:0] el, input string name);
        int   n;
        logic held;
        bus.mdu = cmd; bus.rdata1 = a; bus.rdata2 = b;
        n = 0; held = 1'b1;
        @(negedge clk);
        while (bus.stall === 1'b1 && n < 100) begin
            if (bus.hi !== m_hi || bus.lo !== m_lo) held = 1'b0;
            n++;
            @(negedge clk);
        end
        chk({name, " stall_cycles"}, 32'(n), 32'd33);
        chk({name, " hilo_held"}, {31'd0, held}, 32'd1);
        chk({name, " hi"}, bus.hi, eh);
        chk({name, " lo"}, bus.lo, el);
        m_hi = eh; m_lo = el;
        @(posedge clk); #1;
        bus.mdu = MDU_NONE;
    endtask

    // One-cycle command (none/MTHI/MTLO/7); leaves mdu applied for back-to-back use.
    task automatic do_single(input logic [2:0] cmd, input logic [31:0] a, input string name);
        bus.mdu = cmd; bus.rdata1 = a; bus.rdata2 = $urandom;
        @(negedge clk);
        chk({name, " stall"}, {31'd0, bus.stall}, 32'd0);
        @(posedge clk); #1;
        if (cmd == MDU_MTHI) m_hi = a;
        else if (cmd == MDU_MTLO) m_lo = a;
        chk({name, " hi"}, bus.hi, m_hi);
        chk({name, " lo"}, bus.lo, m_lo);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  cmd;
        logic [31:0] a, b, eh, el;

        tbl[0] = '{MDU_MULT,  32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE};
        tbl[1] = '{MDU_MULTU, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE};
        tbl[2] = '{MDU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[3] = '{MDU_DIVU,  32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF};
        tbl[4] = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
        tbl[5] = '{MDU_DIVU,  32'd100,       32'd3,         32'd1,         32'd33};
        tbl[6] = '{MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
        tbl[7] = '{MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        tbl[8] = '{MDU_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'd1};
        tbl[9] = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};

        // Reset with an iterative command present: nothing may start or stall.
        rst = 1'b1; bus.mdu = MDU_MULT; bus.rdata1 = 32'd5; bus.rdata2 = 32'd6;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset stall", {31'd0, bus.stall}, 32'd0);
        chk("reset hi", bus.hi, 32'd0);
        chk("reset lo", bus.lo, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; bus.mdu = MDU_NONE;

        // Directed vectors, issued back to back as the CPU would after each DONE.
        for (int i = 0; i < 10; i++) begin
            do_iter(tbl[i].cmd, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, $sformatf("vec%0d", i));
        end

        do_single(MDU_MTHI, 32'h0000_1234, "mthi");
        do_single(MDU_MTLO, 32'h0000_5678, "mtlo");
        chk("mt final hi", bus.hi, 32'h0000_1234);
        chk("mt final lo", bus.lo, 32'h0000_5678);

        // Reset in cycle 10 of DIVU 100/3 with the command still held.
        bus.mdu = MDU_DIVU; bus.rdata1 = 32'd100; bus.rdata2 = 32'd3;
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst stall_run", {31'd0, bus.stall}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst stall_idle", {31'd0, bus.stall}, 32'd0);
        chk("midrst hi", bus.hi, 32'd0);
        chk("midrst lo", bus.lo, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; m_hi = 32'd0; m_lo = 32'd0;
        do_iter(MDU_DIVU, 32'd100, 32'd3, 32'd1, 32'd33, "restart");

        // Random commands against the reference model.
        for (int i = 0; i < 40; i++) begin
            cmd = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0:       a = 32'h8000_0000;
                1:       a = 32'($urandom_range(0, 20));
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            if (is_iter(cmd)) begin
                ref_op(cmd, a, b, eh, el);
                do_iter(cmd, a, b, eh, el, $sformatf("rnd%0d cmd%0d", i, cmd));
            end else begin
                do_single(cmd, a, $sformatf("rnd%0d cmd%0d", i, cmd));
                bus.mdu = MDU_NONE;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
